// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
//
// Issue controller that sits between pipeline_decode and the execute stage.
// It keeps a scoreboard of registers with a write in flight and stalls
// decode on RAW and WAW hazards. ECALL and FENCE are serialising: they wait
// until every in-flight write has retired before they issue. After an ECALL
// issues, nothing else issues until sys_done arrives.
//
// State table:
//   state    | meaning
//   RUN      | normal in-order issue
//   DRAIN    | serialising instruction held until the scoreboard is empty
//   SYS_WAIT | ECALL issued; blocking issue until sys_done
//
// Optional feature macro: ISSUE_STALL_COUNTERS_EN
//   defined   -> stall_cycles / sys_cycles are saturating counters
//   undefined -> both counters are tied to 0 and no counter flops are built
//
// Ports:
//   clk, reset            pipeline clock, synchronous active-high reset
//   dec_*                 instruction currently held by decode
//   next_stage_ready      execute can accept this cycle
//   wb_valid, wb_reg      register write retiring this cycle
//   sys_done              one-cycle pulse, ECALL handling finished
//   issue                 instruction accepted into execute this cycle
//   dec_stall             decode must hold its instruction
//   pending_mask          registered scoreboard
//   state                 RUN=0, DRAIN=1, SYS_WAIT=2
//   stall_cycles          cycles with dec_stall high
//   sys_cycles            cycles with state != RUN

module decode_issue_ctrl #(
    parameter int NUM_REGS  = 32,
    parameter int REG_W     = 5,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_valid,
    input  logic [REG_W-1:0]     dec_r1_reg,
    input  logic [REG_W-1:0]     dec_r2_reg,
    input  logic                 dec_uses_r1,
    input  logic                 dec_uses_r2,
    input  logic [REG_W-1:0]     dec_dst_reg,
    input  logic                 dec_writes_dst,
    input  logic                 dec_ecall,
    input  logic                 dec_fence,
    input  logic                 next_stage_ready,
    input  logic                 wb_valid,
    input  logic [REG_W-1:0]     wb_reg,
    input  logic                 sys_done,
    output logic                 issue,
    output logic                 dec_stall,
    output logic [NUM_REGS-1:0]  pending_mask,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] sys_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        SYS_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    logic [NUM_REGS-1:0] clr, set, eff;
    logic                raw_hazard, waw_hazard, hazard;
    logic                serial, eff_empty;
    logic                issue_c;

    // A retiring write is removed before the hazard check so a dependent
    // instruction can issue in the same cycle as its producer's writeback.
    assign clr = wb_valid ? (NUM_REGS'(1) << wb_reg) : '0;
    assign eff = pending_q & ~clr;
    assign eff_empty = (eff == '0);

    // x0 is excluded explicitly even though its scoreboard bit is never set.
    assign raw_hazard = (dec_uses_r1 && (dec_r1_reg != '0) && eff[dec_r1_reg]) ||
                        (dec_uses_r2 && (dec_r2_reg != '0) && eff[dec_r2_reg]);
    assign waw_hazard = dec_writes_dst && (dec_dst_reg != '0) && eff[dec_dst_reg];
    assign hazard     = raw_hazard | waw_hazard;
    assign serial     = dec_ecall | dec_fence;

    always_comb begin
        issue_c = 1'b0;
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (dec_valid) begin
                    if (serial) begin
                        if (eff_empty && next_stage_ready) begin
                            issue_c = 1'b1;
                            if (dec_ecall) state_d = SYS_WAIT;
                        end else if (!eff_empty) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        issue_c = next_stage_ready & ~hazard;
                    end
                end
            end
            DRAIN: begin
                if (dec_valid && eff_empty && next_stage_ready) begin
                    issue_c = 1'b1;
                    state_d = dec_ecall ? SYS_WAIT : RUN;
                end
            end
            SYS_WAIT: begin
                if (sys_done) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            issue_c = 1'b0;
            state_d = RUN;
        end
    end

    // Set is applied after clear so a same-cycle release and re-issue of the
    // same register leaves it pending.
    assign set = (issue_c && dec_writes_dst && (dec_dst_reg != '0))
                 ? (NUM_REGS'(1) << dec_dst_reg) : '0;
    assign pending_d = eff | set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign issue        = issue_c;
    assign dec_stall    = dec_valid & ~issue_c;
    assign pending_mask = pending_q;
    assign state        = state_q;

`ifdef ISSUE_STALL_COUNTERS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, sys_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            sys_cnt_q   <= '0;
        end else begin
            if (dec_stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if ((state_q != RUN) && !(&sys_cnt_q)) sys_cnt_q <= sys_cnt_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign sys_cycles   = sys_cnt_q;
`else
    assign stall_cycles = '0;
    assign sys_cycles   = '0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed testbench for decode_issue_ctrl. Inputs change 1 time unit after
// a rising edge; combinational outputs are checked 1 unit later and
// registered outputs 1 unit after the following rising edge.

module tb_decode_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_r1_reg, dec_r2_reg, dec_dst_reg, wb_reg;
    logic        dec_uses_r1, dec_uses_r2, dec_writes_dst;
    logic        dec_ecall, dec_fence, next_stage_ready;
    logic        wb_valid, sys_done;
    logic        issue, dec_stall;
    logic [31:0] pending_mask;
    logic [1:0]  state;
    logic [31:0] stall_cycles, sys_cycles;

    int tests = 0;
    int fails = 0;

    decode_issue_ctrl #(.NUM_REGS(32), .REG_W(5), .CNT_WIDTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .dec_valid        (dec_valid),
        .dec_r1_reg       (dec_r1_reg),
        .dec_r2_reg       (dec_r2_reg),
        .dec_uses_r1      (dec_uses_r1),
        .dec_uses_r2      (dec_uses_r2),
        .dec_dst_reg      (dec_dst_reg),
        .dec_writes_dst   (dec_writes_dst),
        .dec_ecall        (dec_ecall),
        .dec_fence        (dec_fence),
        .next_stage_ready (next_stage_ready),
        .wb_valid         (wb_valid),
        .wb_reg           (wb_reg),
        .sys_done         (sys_done),
        .issue            (issue),
        .dec_stall        (dec_stall),
        .pending_mask     (pending_mask),
        .state            (state),
        .stall_cycles     (stall_cycles),
        .sys_cycles       (sys_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic instr(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] dst, input logic wd,
                         input logic ec, input logic fe);
        dec_valid      = v;
        dec_r1_reg     = r1;
        dec_uses_r1    = u1;
        dec_r2_reg     = r2;
        dec_uses_r2    = u2;
        dec_dst_reg    = dst;
        dec_writes_dst = wd;
        dec_ecall      = ec;
        dec_fence      = fe;
    endtask

    task automatic idle();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wb(input logic v, input logic [4:0] r);
        wb_valid = v;
        wb_reg   = r;
    endtask

    initial begin
        reset = 1'b1;
        next_stage_ready = 1'b1;
        sys_done = 1'b0;
        wb(1'b0, 5'd0);
        // valid instruction during reset must not issue
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        settle();
        chk("reset_issue", issue, 0);
        chk("reset_stall", dec_stall, 1);
        tick();
        tick();
        chk("reset_mask", pending_mask, 0);
        chk("reset_state", state, 0);
        chk("reset_stall_cnt", stall_cycles, 0);
        chk("reset_sys_cnt", sys_cycles, 0);
        reset = 1'b0;

        // ADDI x5,x1,imm then ADD x6,x5,x1
        instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        settle();
        chk("addi_issue", issue, 1);
        tick();
        chk("addi_mask", pending_mask, 32'h20);
        instr(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        settle();
        chk("raw_c1_issue", issue, 0);
        chk("raw_c1_stall", dec_stall, 1);
        tick();
        settle();
        chk("raw_c2_issue", issue, 0);
        tick();
        wb(1'b1, 5'd5);
        settle();
        chk("raw_c3_issue", issue, 1);
        chk("raw_c3_stall", dec_stall, 0);
        tick();
        chk("raw_mask", pending_mask, 32'h40);
        idle();
        wb(1'b1, 5'd6);
        tick();
        wb(1'b0, 5'd0);
        chk("clr6_mask", pending_mask, 0);

        // writeback of a register that is not pending is a no-op
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        wb(1'b1, 5'd12);
        tick();
        wb(1'b0, 5'd0);
        chk("wb_nonpending_mask", pending_mask, 32'h800);
        wb(1'b1, 5'd11);
        tick();
        wb(1'b0, 5'd0);

        // ADDI x0,x0,1 then ADD x2,x0,x0
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("x0_addi_issue", issue, 1);
        tick();
        chk("x0_addi_mask", pending_mask, 0);
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        settle();
        chk("x0_add_issue", issue, 1);
        tick();
        chk("x0_add_mask", pending_mask, 32'h4);
        idle();
        wb(1'b1, 5'd2);
        tick();
        wb(1'b0, 5'd0);

        // x7 pending, then ECALL drains, issues, waits for sys_done
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        chk("x7_mask", pending_mask, 32'h80);
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("ecall_run_issue", issue, 0);
        tick();
        chk("ecall_drain_state", state, 1);
        chk("ecall_drain_stall", dec_stall, 1);
        wb(1'b1, 5'd7);
        settle();
        chk("ecall_drain_issue", issue, 1);
        tick();
        wb(1'b0, 5'd0);
        chk("ecall_sys_state", state, 2);
        chk("ecall_sys_mask", pending_mask, 0);
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        settle();
        chk("syswait_c1_issue", issue, 0);
        tick();
        tick();
        settle();
        chk("syswait_c3_stall", dec_stall, 1);
        tick();
        sys_done = 1'b1;
        settle();
        chk("syswait_c4_issue", issue, 0);
        tick();
        sys_done = 1'b0;
        chk("sysdone_state", state, 0);
        chk("after_sys_issue", issue, 1);
        tick();
        chk("after_sys_mask", pending_mask, 32'h8);
        idle();
        wb(1'b1, 5'd3);
        tick();
        wb(1'b0, 5'd0);

        // FENCE on an empty scoreboard issues at once and stays in RUN
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("fence_issue", issue, 1);
        tick();
        chk("fence_state", state, 0);
        // stray sys_done in RUN is ignored
        idle();
        sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        chk("stray_sysdone_state", state, 0);

        // release and re-issue of x9 in the same cycle: set wins
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        chk("x9_mask", pending_mask, 32'h200);
        wb(1'b1, 5'd9);
        settle();
        chk("x9_reissue_issue", issue, 1);
        tick();
        chk("x9_set_wins_mask", pending_mask, 32'h200);
        next_stage_ready = 1'b0;
        settle();
        chk("x9_notready_issue", issue, 0);
        tick();
        chk("x9_clear_mask", pending_mask, 0);
        next_stage_ready = 1'b1;
        wb(1'b0, 5'd0);
        idle();

        // reset while DRAIN with x8,x9 pending
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        chk("pre_reset_mask", pending_mask, 32'h300);
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("pre_reset_drain", state, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk("rst_drain_state", state, 0);
        chk("rst_drain_mask", pending_mask, 0);
        chk("rst_drain_sys_cnt", sys_cycles, 0);

        // reset while SYS_WAIT discards the owed sys_done
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        chk("pre_reset_syswait", state, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_sys_state", state, 0);
        chk("rst_sys_stall_cnt", stall_cycles, 0);
        chk("rst_sys_sys_cnt", sys_cycles, 0);
        sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        chk("late_sysdone_state", state, 0);

        // exactly 10 stall cycles on a RAW against x4
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        instr(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        idle();
        settle();
`ifdef ISSUE_STALL_COUNTERS_EN
        chk("stall_cnt_10", stall_cycles, 10);
`else
        chk("stall_cnt_tied", stall_cycles, 0);
`endif
        chk("sys_cnt_run", sys_cycles, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
